// File: rtl/ins_encoder.sv
// Instruction encoder and program loader: packs decoded instruction fields into
// 16-bit words, buffers them in a FIFO and writes them sequentially to instruction memory.
module ins_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_valid,
  output logic        enc_ready,
  input  logic [1:0]  Ins_mode,
  input  logic [1:0]  Ins_byte,
  input  logic [3:0]  Ins_Opcode,
  input  logic [2:0]  Ins_Op1,
  input  logic [2:0]  Ins_Op2,
  input  logic [1:0]  Ins_OT,
  input  logic        prog_clear,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] prog_count,
  output logic        mem_full
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] LAST_ADDR = BASE_ADDR + 16'(MEM_WORDS - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [15:0] pack_fields(
    input logic [1:0] mode, input logic [1:0] byt, input logic [3:0] opc,
    input logic [2:0] op1,  input logic [2:0] op2, input logic [1:0] ot
  );
    return {mode, byt, opc, op1, op2, ot};
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [15:0]   fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic [15:0]   addr_r;
  logic [15:0]   wdata_r;
  logic [15:0]   count_r;
  logic          mem_full_r;
  logic          mem_we_s;
  logic          enc_ready_s;
  logic          clear_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  logic          last_s;
  logic [15:0]   packed_s;

  assign clear_s      = rst || prog_clear;
  assign fifo_full_s  = (cnt_r == DEPTH_CNT);
  assign fifo_empty_s = (cnt_r == {(AW + 1){1'b0}});
  assign push_s       = enc_valid && enc_ready_s;
  assign pop_s        = (state_r == ST_WRITE) && mem_ready;
  assign last_s       = (addr_r == LAST_ADDR);
  assign packed_s     = pack_fields(Ins_mode, Ins_byte, Ins_Opcode, Ins_Op1, Ins_Op2, Ins_OT);

  // State register
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) state_next_s = ST_WRITE;
        else               state_next_s = ST_IDLE;
      end
      ST_WRITE: begin
        if (mem_ready) state_next_s = last_s ? ST_FULL : ST_IDLE;
        else           state_next_s = ST_WRITE;
      end
      ST_FULL:  state_next_s = ST_FULL;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode; ready depends only on registered occupancy and the full flag
  always_comb begin
    mem_we_s    = 1'b0;
    enc_ready_s = !fifo_full_s && !mem_full_r;
    if (state_r == ST_WRITE) mem_we_s = 1'b1;
    else                     mem_we_s = 1'b0;
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s && !clear_s) begin
      fifo_mem_r[wr_ptr_r] <= packed_s;
    end
  end

  // FIFO pointers, write address, word count and captured write data
  always_ff @(posedge clk) begin
    if (clear_s) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      cnt_r      <= {(AW + 1){1'b0}};
      addr_r     <= BASE_ADDR;
      count_r    <= 16'd0;
      mem_full_r <= 1'b0;
      wdata_r    <= 16'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        count_r  <= count_r + 16'd1;
        if (last_s) mem_full_r <= 1'b1;
        else        addr_r     <= addr_r + 16'd1;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      // Head is latched on the way into WRITE so data stays put while stalled
      if ((state_r == ST_IDLE) && !fifo_empty_s) wdata_r <= fifo_mem_r[rd_ptr_r];
    end
  end

  assign enc_ready  = enc_ready_s;
  assign mem_we     = mem_we_s;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign prog_count = count_r;
  assign mem_full   = mem_full_r;

endmodule
